// File: rtl/pwm_generator_if.sv
// Duty-request handshake between a controller and the PWM generator.
// A request transfers on any rising edge where duty_valid && duty_ready.
interface pwm_generator_if #(
    parameter int DUTY_W = 5
);
    logic              duty_valid;
    logic [DUTY_W-1:0] duty_in;
    logic              duty_ready;
    logic              duty_err;

    modport master (
        output duty_valid,
        output duty_in,
        input  duty_ready,
        input  duty_err
    );

    modport slave (
        input  duty_valid,
        input  duty_in,
        output duty_ready,
        output duty_err
    );
endinterface

// File: rtl/pwm_generator.sv
// Fixed-period PWM with a divided square-wave clock and period-start strobe.
// Duty updates are double-buffered so they only take effect on a period boundary.
module pwm_generator #(
    parameter int PERIOD_LOG2 = 4
) (
    input  logic             clk_3125KHz,
    input  logic             reset,
    pwm_generator_if.slave   duty_bus,
    output logic             clk_195KHz,
    output logic             pwm_signal,
    output logic             period_start
);
    localparam int             DW       = PERIOD_LOG2 + 1;
    localparam logic [DW-1:0]  DUTY_MAX = DW'(1 << PERIOD_LOG2);

    logic [PERIOD_LOG2-1:0] cnt;
    logic [DW-1:0]          duty_active;
    logic [DW-1:0]          pending_duty;
    logic                   pending_full;
    logic                   duty_ready_q;
    logic                   duty_err_q;

    logic xfer;
    logic legal;
    logic last_cycle;

    assign xfer       = duty_bus.duty_valid && duty_ready_q;
    assign legal      = (duty_bus.duty_in <= DUTY_MAX);
    assign last_cycle = (cnt == '1);

    assign duty_bus.duty_ready = duty_ready_q;
    assign duty_bus.duty_err   = duty_err_q;

    always_ff @(posedge clk_3125KHz) begin
        if (reset) begin
            cnt          <= '0;
            duty_active  <= '0;
            pending_duty <= '0;
            pending_full <= 1'b0;
            duty_ready_q <= 1'b1;
            duty_err_q   <= 1'b0;
            clk_195KHz   <= 1'b0;
            pwm_signal   <= 1'b0;
            period_start <= 1'b0;
        end else begin
            cnt          <= cnt + 1'b1;
            // Outputs use the pre-increment count, so they trail cnt by one cycle.
            clk_195KHz   <= ~cnt[PERIOD_LOG2-1];
            pwm_signal   <= ({1'b0, cnt} < duty_active);
            period_start <= (cnt == '0);
            duty_err_q   <= xfer && !legal;

            if (last_cycle) begin
                if (pending_full) begin
                    duty_active  <= pending_duty;
                    pending_full <= 1'b0;
                    duty_ready_q <= 1'b1;
                end else if (xfer && legal) begin
                    // Request landing on the boundary goes straight to the active register.
                    duty_active <= duty_bus.duty_in;
                end
            end else if (xfer && legal) begin
                pending_duty <= duty_bus.duty_in;
                pending_full <= 1'b1;
                duty_ready_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_pwm_generator.sv
// Self-checking bench for pwm_generator: directed scenarios plus random duty
// traffic, compared against a period-level reference model.
module tb_pwm_generator;
    logic clk_3125KHz = 1'b0;
    logic reset       = 1'b1;
    logic clk_195KHz, pwm_signal, period_start;

    pwm_generator_if bus ();

    pwm_generator dut (
        .clk_3125KHz (clk_3125KHz),
        .reset       (reset),
        .duty_bus    (bus.slave),
        .clk_195KHz  (clk_195KHz),
        .pwm_signal  (pwm_signal),
        .period_start(period_start)
    );

    always #5 clk_3125KHz = ~clk_3125KHz;

    int total = 0;
    int bad   = 0;

    // Reference model: k is the index of the next edge since reset release.
    int   k;
    int   cur_duty;
    int   nxt_duty;
    bit   has_nxt;
    int   pend_end;
    logic exp_clk, exp_pwm, exp_ps, exp_ready, exp_err;

    function automatic logic [4:0] obs_vec();
        return {clk_195KHz, pwm_signal, period_start, bus.duty_ready, bus.duty_err};
    endfunction

    function automatic logic [4:0] exp_vec();
        return {exp_clk, exp_pwm, exp_ps, exp_ready, exp_err};
    endfunction

    task automatic model_reset();
        k = 0; cur_duty = 0; nxt_duty = 0; has_nxt = 0; pend_end = 0;
        exp_clk = 0; exp_pwm = 0; exp_ps = 0; exp_ready = 1; exp_err = 0;
    endtask

    task automatic reset_edge();
        @(negedge clk_3125KHz);
        reset = 1'b1;
        bus.duty_valid = 1'b0;
        bus.duty_in    = 5'd0;
        @(posedge clk_3125KHz);
        #1;
        model_reset();
    endtask

    // Drives one cycle of stimulus and advances the model; no checking here.
    task automatic run_cycle(input logic v, input logic [4:0] d);
        int ph;
        bit xfer;
        @(negedge clk_3125KHz);
        reset          = 1'b0;
        bus.duty_valid = v;
        bus.duty_in    = d;
        ph   = k % 16;
        xfer = v && exp_ready;
        @(posedge clk_3125KHz);
        #1;
        exp_clk = (ph < 8);
        exp_ps  = (ph == 0);
        exp_pwm = (ph < cur_duty);
        exp_err = xfer && (d > 16);
        if (xfer && d <= 16) begin
            nxt_duty = d;
            has_nxt  = 1;
            pend_end = k - ph + 15;
        end
        if (ph == 15 && has_nxt) begin
            cur_duty = nxt_duty;
            has_nxt  = 0;
        end
        exp_ready = !(has_nxt && k < pend_end);
        k++;
    endtask

    task automatic test_reset();
        reset_edge();
        reset_edge();
        total++;
        if (obs_vec() !== 5'b00010) begin
            bad++;
            $display("FAIL reset_values got=%b want=%b", obs_vec(), 5'b00010);
        end
        run_cycle(0, 0);
        total++;
        if ({clk_195KHz, period_start, pwm_signal} !== 3'b110) begin
            bad++;
            $display("FAIL first_edge_after_reset got=%b want=110",
                     {clk_195KHz, period_start, pwm_signal});
        end
    endtask

    task automatic test_idle();
        int highs = 0;
        int starts = 0;
        for (int i = 0; i < 31; i++) begin
            run_cycle(0, 0);
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL idle k=%0d got=%b want=%b", k, obs_vec(), exp_vec());
            end
            if (i >= 15) begin
                highs  += int'(clk_195KHz);
                starts += int'(period_start);
            end
        end
        total++;
        if (highs !== 8 || starts !== 1) begin
            bad++;
            $display("FAIL idle_shape clk_highs=%0d starts=%0d want 8 and 1", highs, starts);
        end
    endtask

    task automatic test_duty5();
        int highs = 0;
        while (k % 16 != 3) begin
            run_cycle(0, 0);
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL duty5_pre k=%0d got=%b want=%b", k, obs_vec(), exp_vec());
            end
        end
        run_cycle(1, 5);
        total++;
        if (bus.duty_ready !== 1'b0) begin
            bad++;
            $display("FAIL duty5_ready_drop got=%b want=0", bus.duty_ready);
        end
        // Out-of-range request while not ready must be ignored silently.
        run_cycle(1, 25);
        total++;
        if (bus.duty_err !== 1'b0 || obs_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL duty5_ignored got=%b want=%b", obs_vec(), exp_vec());
        end
        while (k % 16 != 0) begin
            run_cycle(0, 0);
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL duty5_wait k=%0d got=%b want=%b", k, obs_vec(), exp_vec());
            end
        end
        for (int i = 0; i < 16; i++) begin
            run_cycle(0, 0);
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL duty5_period k=%0d got=%b want=%b", k, obs_vec(), exp_vec());
            end
            if (i == 0) begin
                total++;
                if ({pwm_signal, period_start} !== 2'b11) begin
                    bad++;
                    $display("FAIL duty5_rise_align got=%b want=11", {pwm_signal, period_start});
                end
            end
            highs += int'(pwm_signal);
        end
        total++;
        if (highs !== 5) begin
            bad++;
            $display("FAIL duty5_highs got=%0d want=5", highs);
        end
    endtask

    task automatic test_full_empty();
        int highs;
        while (k % 16 != 5) begin
            run_cycle(0, 0);
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL fe_pre k=%0d got=%b want=%b", k, obs_vec(), exp_vec());
            end
        end
        run_cycle(1, 16);
        while (k % 16 != 0) begin
            run_cycle(0, 0);
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL fe_wait k=%0d got=%b want=%b", k, obs_vec(), exp_vec());
            end
        end
        highs = 0;
        for (int i = 0; i < 16; i++) begin
            run_cycle(i == 5, 5'd0);
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL fe_full k=%0d got=%b want=%b", k, obs_vec(), exp_vec());
            end
            highs += int'(pwm_signal);
        end
        total++;
        if (highs !== 16) begin
            bad++;
            $display("FAIL fe_full_highs got=%0d want=16", highs);
        end
        highs = 0;
        for (int i = 0; i < 16; i++) begin
            run_cycle(0, 0);
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL fe_empty k=%0d got=%b want=%b", k, obs_vec(), exp_vec());
            end
            highs += int'(pwm_signal);
        end
        total++;
        if (highs !== 0) begin
            bad++;
            $display("FAIL fe_empty_highs got=%0d want=0", highs);
        end
    endtask

    task automatic test_err();
        int highs = 0;
        run_cycle(1, 5'd20);
        total++;
        if ({bus.duty_err, bus.duty_ready} !== 2'b11) begin
            bad++;
            $display("FAIL err_pulse err_ready=%b want=11", {bus.duty_err, bus.duty_ready});
        end
        run_cycle(0, 0);
        total++;
        if ({bus.duty_err, bus.duty_ready} !== 2'b01) begin
            bad++;
            $display("FAIL err_one_cycle err_ready=%b want=01", {bus.duty_err, bus.duty_ready});
        end
        while (k % 16 != 0) run_cycle(0, 0);
        for (int i = 0; i < 16; i++) begin
            run_cycle(0, 0);
            highs += int'(pwm_signal);
        end
        total++;
        if (highs !== 0) begin
            bad++;
            $display("FAIL err_duty_unchanged highs=%0d want=0", highs);
        end
    endtask

    task automatic test_bypass();
        int highs = 0;
        while (k % 16 != 15) run_cycle(0, 0);
        run_cycle(1, 5'd9);
        total++;
        if (bus.duty_ready !== 1'b1) begin
            bad++;
            $display("FAIL bypass_ready got=%b want=1", bus.duty_ready);
        end
        for (int i = 0; i < 16; i++) begin
            run_cycle(0, 0);
            total++;
            if (obs_vec() !== exp_vec() || bus.duty_ready !== 1'b1) begin
                bad++;
                $display("FAIL bypass_period k=%0d got=%b want=%b", k, obs_vec(), exp_vec());
            end
            highs += int'(pwm_signal);
        end
        total++;
        if (highs !== 9) begin
            bad++;
            $display("FAIL bypass_highs got=%0d want=9", highs);
        end
    endtask

    task automatic test_reset_mid();
        int highs = 0;
        while (k % 16 != 2) run_cycle(0, 0);
        run_cycle(1, 5'd12);
        while (k % 16 != 7) run_cycle(0, 0);
        reset_edge();
        total++;
        if (obs_vec() !== 5'b00010) begin
            bad++;
            $display("FAIL reset_mid_values got=%b want=00010", obs_vec());
        end
        for (int i = 0; i < 32; i++) begin
            run_cycle(0, 0);
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL reset_mid_after k=%0d got=%b want=%b", k, obs_vec(), exp_vec());
            end
            highs += int'(pwm_signal);
        end
        total++;
        if (highs !== 0) begin
            bad++;
            $display("FAIL reset_mid_pwm highs=%0d want=0", highs);
        end
    endtask

    task automatic test_random();
        logic       v;
        logic [4:0] d;
        for (int i = 0; i < 600; i++) begin
            v = ($urandom_range(0, 9) < 3);
            d = 5'($urandom_range(0, 20));
            run_cycle(v, d);
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL random k=%0d v=%b d=%0d got=%b want=%b",
                         k, v, d, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        bus.duty_valid = 1'b0;
        bus.duty_in    = 5'd0;
        model_reset();
        test_reset();
        test_idle();
        test_duty5();
        test_full_empty();
        test_err();
        test_bypass();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
